dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 100 ++++++++++
 tb/tb_dmem_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory answering one MEM-stage request
// at a time with a fixed, parameterised response latency. Requests that are
// misaligned or outside the array are flagged and never touch the array.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [2**ADDR_W];

    logic              accept;
    logic              enter_resp;
    logic              op_we;
    logic [31:0]       op_addr, op_wdata;
    logic              op_err;
    logic [ADDR_W-1:0] op_idx;

    assign req_ready  = (state == IDLE) && !reset_0;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // With LATENCY=1 the edge entering RESP is the accepting edge itself, so
    // the operation comes straight from the inputs; otherwise from the latch.
    assign op_we      = (state == IDLE) ? req_we    : we_q;
    assign op_addr    = (state == IDLE) ? req_addr  : addr_q;
    assign op_wdata   = (state == IDLE) ? req_wdata : wdata_q;
    assign op_err     = (op_addr[1:0] != 2'b00) || ((op_addr >> (ADDR_W + 2)) != 32'd0);
    assign op_idx     = op_addr[ADDR_W+1:2];
    assign enter_resp = (state_nxt == RESP) && !reset_0;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) state_nxt = RESP;
                    else              state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter and registered response; reset aborts any request.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                resp_err   <= op_err;
                resp_rdata <= (op_err || op_we) ? 32'd0 : mem[op_idx];
            end
        end
    end

    // Capture the request so later input changes are ignored.
    always_ff @(posedge clock) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Array write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clock) begin
        if (enter_resp && op_we && !op_err) mem[op_idx] <= op_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 3, 1) checked against
// a word-array reference model with directed and random transactions.
module tb_dmem_responder;

    logic             clock = 1'b0;
    logic [2:0]       rst, valid, ready, we, rvalid, rerr;
    logic [2:0][31:0] addr, wdata, rdata;

    int tests = 0;
    int fails = 0;
    int lat[3] = '{2, 3, 1};

    logic [31:0] mm [3][256];
    bit          kn [3][256];

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_l2 (
        .clock(clock), .reset_0(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .resp_valid(rvalid[0]), .resp_rdata(rdata[0]), .resp_err(rerr[0]));
    dmem_responder #(.ADDR_W(8), .LATENCY(3)) u_l3 (
        .clock(clock), .reset_0(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .resp_valid(rvalid[1]), .resp_rdata(rdata[1]), .resp_err(rerr[1]));
    dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_l1 (
        .clock(clock), .reset_0(rst[2]), .req_valid(valid[2]), .req_ready(ready[2]),
        .req_we(we[2]), .req_addr(addr[2]), .req_wdata(wdata[2]),
        .resp_valid(rvalid[2]), .resp_rdata(rdata[2]), .resp_err(rerr[2]));

    // Reference: 256 words, byte address a; legal iff word aligned and a/4 < 256.
    function automatic void model_exp(input int d, input bit wr, input logic [31:0] a,
                                      input logic [31:0] wd, output logic [31:0] er,
                                      output bit ee, output bit ck);
        ee = (a % 4 != 0) || (a / 4 >= 256);
        er = 32'd0;
        ck = 1'b1;
        if (!ee) begin
            if (wr) begin
                mm[d][a/4] = wd;
                kn[d][a/4] = 1'b1;
            end else begin
                er = mm[d][a/4];
                ck = kn[d][a/4];
            end
        end
    endfunction

    task automatic txn(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        logic [31:0] er, hr;
        bit          ee, ck, he;
        int          n;
        @(negedge clock);
        valid[d] = 1'b1; we[d] = wr; addr[d] = a; wdata[d] = wd;
        n = 0;
        while (!ready[d] && n < 20) begin @(negedge clock); n++; end
        if (!ready[d]) begin
            tests++; fails++;
            $display("FAIL %s accept: req_ready stayed %b, want 1", tag, ready[d]);
            valid[d] = 1'b0;
            return;
        end
        model_exp(d, wr, a, wd, er, ee, ck);
        @(negedge clock);
        valid[d] = 1'b0; we[d] = ~wr; addr[d] = $urandom; wdata[d] = $urandom;
        n = 1;
        while (!rvalid[d] && n < 20) begin @(negedge clock); n++; end
        tests++;
        if (!rvalid[d] || n != lat[d]) begin
            fails++;
            $display("FAIL %s latency: got %0d cycles (resp_valid=%b), want %0d", tag, n, rvalid[d], lat[d]);
        end
        if (rvalid[d]) begin
            tests++;
            if (rerr[d] !== ee) begin
                fails++;
                $display("FAIL %s err: got %b, want %b", tag, rerr[d], ee);
            end
            if (ck) begin
                tests++;
                if (rdata[d] !== er) begin
                    fails++;
                    $display("FAIL %s rdata: got %h, want %h", tag, rdata[d], er);
                end
            end
            hr = rdata[d]; he = rerr[d];
            @(negedge clock);
            tests++;
            if (rvalid[d] !== 1'b0 || rdata[d] !== hr || rerr[d] !== he) begin
                fails++;
                $display("FAIL %s hold: got valid=%b rdata=%h err=%b, want valid=0 rdata=%h err=%b",
                         tag, rvalid[d], rdata[d], rerr[d], hr, he);
            end
        end
    endtask

    task automatic test_reset();
        rst = 3'b111; valid = 3'b111;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (ready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'd0 || rerr[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d]: got ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
                         d, ready[d], rvalid[d], rdata[d], rerr[d]);
            end
        end
        valid = 3'b000; rst = 3'b000;
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (ready[d] !== 1'b1 || rvalid[d] !== 1'b0) begin
                fails++;
                $display("FAIL post_reset[%0d]: got ready=%b valid=%b, want 1 0", d, ready[d], rvalid[d]);
            end
        end
    endtask

    task automatic test_basic();
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "basic_store");
        txn(0, 1'b0, 32'h10, 32'h0, "basic_load");
    endtask

    task automatic test_errors();
        txn(0, 1'b1, 32'h0, 32'hA5A5_0001, "err_prewrite0");
        txn(0, 1'b0, 32'h402, 32'h0, "misaligned_load");
        txn(0, 1'b1, 32'h402, 32'hFFFF_FFFF, "misaligned_store");
        txn(0, 1'b0, 32'h0, 32'h0, "misaligned_word0");
        txn(0, 1'b1, 32'h400, 32'h1111_2222, "oob_store");
        txn(0, 1'b0, 32'h0, 32'h0, "oob_word0");
        txn(0, 1'b0, 32'h8000_0000, 32'h0, "oob_high_load");
    endtask

    task automatic test_random(input int d, input int cnt);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < cnt; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) * 32'd4;
            if (r == 8) a = a | 32'($urandom_range(1, 3));
            if (r == 9) a = a + (32'd1 << $urandom_range(10, 31));
            txn(d, r < 5, a, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        bit          wl[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] al[4] = '{32'h40, 32'h40, 32'h44, 32'h44};
        logic [31:0] dl[4];
        int          qd[$];
        logic [31:0] qr[$];
        bit          qe[$], qc[$];
        logic [31:0] er, r;
        bit          ee, ck, e, k, pend;
        int          acc, last, due;
        for (int i = 0; i < 4; i++) dl[i] = $urandom;
        @(negedge clock);
        valid[1] = 1'b1; we[1] = wl[0]; addr[1] = al[0]; wdata[1] = dl[0];
        acc = 0; last = -1; pend = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (rvalid[1]) begin
                tests++;
                if (qd.size() == 0) begin
                    fails++;
                    $display("FAIL b2b spurious resp at cycle %0d", c);
                end else begin
                    due = qd.pop_front(); r = qr.pop_front(); e = qe.pop_front(); k = qc.pop_front();
                    if (c != due || rerr[1] !== e || (k && rdata[1] !== r) || ready[1] !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b resp: got cyc=%0d rdata=%h err=%b ready=%b, want cyc=%0d rdata=%h err=%b ready=0",
                                 c, rdata[1], rerr[1], ready[1], due, r, e);
                    end
                end
            end
            if (ready[1] && valid[1]) begin
                if (last >= 0) begin
                    tests++;
                    if (c - last != 4) begin
                        fails++;
                        $display("FAIL b2b gap: got %0d cycles, want 4", c - last);
                    end
                end
                last = c;
                model_exp(1, we[1], addr[1], wdata[1], er, ee, ck);
                qd.push_back(c + 3); qr.push_back(er); qe.push_back(ee); qc.push_back(ck);
                acc++;
                pend = 1'b1;
            end
            if (acc == 4 && qd.size() == 0) break;
            @(negedge clock);
            if (pend) begin
                if (acc < 4) begin
                    we[1] = wl[acc]; addr[1] = al[acc]; wdata[1] = dl[acc];
                end else valid[1] = 1'b0;
                pend = 1'b0;
            end
        end
        valid[1] = 1'b0;
        tests++;
        if (acc != 4 || qd.size() != 0) begin
            fails++;
            $display("FAIL b2b timeout: got %0d accepts %0d pending, want 4 accepts 0 pending", acc, qd.size());
        end
    endtask

    task automatic test_reset_abort();
        int n, seen;
        txn(0, 1'b1, 32'h20, 32'hCAFE_0020, "abort_prior");
        @(negedge clock);
        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
        n = 0;
        while (!ready[0] && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        valid[0] = 1'b0;
        rst[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid[0]) seen++;
            @(negedge clock);
            rst[0] = 1'b0;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort resp_valid: got %0d pulses, want 0", seen);
        end
        txn(0, 1'b0, 32'h20, 32'h0, "abort_load");
    endtask

    task automatic test_latency1();
        txn(2, 1'b1, 32'h30, 32'h0BAD_F00D, "l1_store");
        txn(2, 1'b0, 32'h30, 32'h0, "l1_load");
        txn(2, 1'b1, 32'h34, 32'h7654_3210, "l1_store2");
        txn(2, 1'b0, 32'h34, 32'h0, "l1_load2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 3'b111; valid = 3'b000; we = 3'b000; addr = '0; wdata = '0;
        test_reset();
        test_basic();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_latency1();
        test_random(0, 30);
        test_random(1, 12);
        test_random(2, 12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
